serial_add_ctrl: RTL and testbench

- Bit-serial addition sequencer. Shares one 1-bit full-adder slice, built from two half_adder instances plus an OR gate, across all bit positions of a WIDTH-bit add.
- Latches two operands on a start handshake and shifts them LSB-first through the slice, one bit per clock.
- Holds the inter-bit carry in a flop and assembles the result in a shift register.
- Sits between a requester issuing add commands and the shared half_adder datapath. Gives an area-minimal alternative to a parallel ripple adder.

---
 rtl/serial_add_ctrl.sv | 166 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder slice (two half adders + OR) walks a WIDTH-bit add LSB-first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the sub_in port).

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_in,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             op_inv;
  logic             ha0_s, ha0_c, ha1_c;
  logic             slice_sum, slice_carry;
  logic             last_bit;

`ifdef SERIAL_ADD_SUB_EN
  assign op_inv = sub_in;
`else
  assign op_inv = 1'b0;
`endif

  // Shared full-adder slice; subtract reuses it as A + ~B + 1.
  half_adder u_ha0 (
    .a (a_q[0]),
    .b (b_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .a (ha0_s),
    .b (carry_q),
    .s (slice_sum),
    .c (ha1_c)
  );

  assign slice_carry = ha0_c | ha1_c;
  assign last_bit    = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = op_inv ? ~b_in : b_in;
          carry_d = op_inv;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_d   = (res_q >> 1) | (WIDTH'(slice_sum) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = res_d;
          cout_d  = slice_carry;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=4: vector table plus hand-written multi-cycle sequences.
// Subtract vectors are included when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub_in;
`endif
  logic         ready, busy, done;
  logic [W-1:0] sum_out;
  logic         carry_out;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub_in    (sub_in),
`endif
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   ncmp     = 0;
  int   errs     = 0;
  int   done_cnt = 0;

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                              input logic [W-1:0] s, input logic c);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.s = s; v.c = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        ncmp++;
        errs++;
        $display("FAIL unexpected_done: got sum %0d carry %0b, required no done pulse", sum_out, carry_out);
      end else begin
        e = sb.pop_front();
        check("sum_out", 32'(sum_out), 32'(e.s));
        check("carry_out", 32'(carry_out), 32'(e.c));
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 30; i++) begin
      if (ready) break;
      @(negedge clk);
    end
    check("wait_ready", 32'(ready), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    a_in  = v.a;
    b_in  = v.b;
`ifdef SERIAL_ADD_SUB_EN
    sub_in = v.sub;
`endif
    start = 1'b1;
  endtask

  task automatic run_add(input vec_t v);
    int busy_n;
    int done_at;
    exp_t e;
    wait_ready();
    drive(v);
    e.s = v.s;
    e.c = v.c;
    sb.push_back(e);
    busy_n  = 0;
    done_at = 0;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done && done_at == 0) done_at = k;
      if (k == W + 2) check("done_one_cycle", 32'(done), 32'd0);
      start = 1'b0;
      a_in  = W'($urandom());
      b_in  = W'($urandom());
    end
    check("busy_cycles", 32'(busy_n), 32'(W));
    check("done_latency", 32'(done_at), 32'(W + 1));
    check("ready_after_done", 32'(ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   prev;
    int   dk[$];
    logic hold_ok;
    exp_t e;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub_in = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sum", 32'(sum_out), 32'd0);
    check("idle_no_done", 32'(done_cnt), 32'd0);

    tbl.push_back(mk(4'd5,  4'd3,  1'b0, 4'b1000, 1'b0));
    tbl.push_back(mk(4'd0,  4'd0,  1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(4'd15, 4'd1,  1'b0, 4'b0000, 1'b1));
    tbl.push_back(mk(4'd15, 4'd15, 1'b0, 4'b1110, 1'b1));
    tbl.push_back(mk(4'd9,  4'd9,  1'b0, 4'b0010, 1'b1));
    tbl.push_back(mk(4'd10, 4'd5,  1'b0, 4'b1111, 1'b0));
    tbl.push_back(mk(4'd8,  4'd8,  1'b0, 4'b0000, 1'b1));
`ifdef SERIAL_ADD_SUB_EN
    tbl.push_back(mk(4'd3,  4'd5,  1'b1, 4'b1110, 1'b0));
    tbl.push_back(mk(4'd9,  4'd4,  1'b1, 4'b0101, 1'b1));
    tbl.push_back(mk(4'd7,  4'd2,  1'b0, 4'b1001, 1'b0));
    tbl.push_back(mk(4'd0,  4'd1,  1'b1, 4'b1111, 1'b0));
`endif
    foreach (tbl[i]) run_add(tbl[i]);

    // Start pulsed mid-RUN is ignored.
    wait_ready();
    prev = done_cnt;
    drive(mk(4'd5, 4'd3, 1'b0, 4'd0, 1'b0));
    e.s = 4'd8; e.c = 1'b0;
    sb.push_back(e);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      start = (k == 2);
      if (k == 2) begin
        a_in = 4'd1;
        b_in = 4'd1;
      end
    end
    repeat (W + 4) @(negedge clk);
    check("busy_start_one_done", 32'(done_cnt - prev), 32'd1);
    check("busy_start_ready", 32'(ready), 32'd1);

    // Start held high: one acceptance every W+2 cycles.
    wait_ready();
    prev = done_cnt;
    a_in  = 4'd1;
    b_in  = 4'd2;
    start = 1'b1;
    e.s = 4'd3; e.c = 1'b0;
    repeat (3) sb.push_back(e);
    for (int k = 1; k <= 3 * (W + 2); k++) begin
      @(negedge clk);
      if (done) dk.push_back(k);
      if (k == 3 * (W + 2)) start = 1'b0;
    end
    repeat (W + 3) @(negedge clk);
    check("b2b_done_count", 32'(dk.size()), 32'd3);
    check("b2b_first", 32'(dk[0]), 32'(W + 1));
    check("b2b_gap1", 32'(dk[1] - dk[0]), 32'(W + 2));
    check("b2b_gap2", 32'(dk[2] - dk[1]), 32'(W + 2));
    check("b2b_no_fourth", 32'(done_cnt - prev), 32'd3);

    // Reset in the 2nd RUN cycle aborts without a done pulse.
    wait_ready();
    prev = done_cnt;
    drive(mk(4'd15, 4'd15, 1'b0, 4'd0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sum", 32'(sum_out), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (W + 3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - prev), 32'd0);
    run_add(mk(4'd2, 4'd2, 1'b0, 4'd4, 1'b0));

    // Previous result holds through the next RUN.
    run_add(mk(4'd7, 4'd6, 1'b0, 4'b1101, 1'b0));
    wait_ready();
    drive(mk(4'd1, 4'd1, 1'b0, 4'd0, 1'b0));
    e.s = 4'd2; e.c = 1'b0;
    sb.push_back(e);
    hold_ok = 1'b1;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sum_out !== 4'd13) hold_ok = 1'b0;
    end
    check("hold_through_run", 32'(hold_ok), 32'd1);
    @(negedge clk);
    check("hold_done", 32'(done), 32'd1);
    @(negedge clk);
    check("hold_after_done", 32'(sum_out), 32'd2);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, errs);
    $finish;
  end

endmodule
